// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for MULT/MULTU: N add/shift iterations plus one
// sign-fixup edge, so a result lands on o_HI/o_LO N+1 edges after the start edge.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for i_start
// RUN    | one add/shift iteration per edge, N edges total (o_busy=1)
// FIX    | applies the sign to the magnitude product and loads o_HI/o_LO
// DONE   | result valid, o_done=1 for this single cycle; i_start re-arms
module seq_multiplier #(
    parameter int N = 32
) (
    input  logic         i_CLK,
    input  logic         i_RST,
    input  logic         i_start,
    input  logic         i_signed,
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_HI,
    output logic [N-1:0] o_LO
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [N-1:0]     mcand;
    logic [2*N:0]     acc;
    logic             neg;

    logic             start_ok;
    logic             last_iter;
    logic [N-1:0]     a_mag;
    logic [N-1:0]     b_mag;
    logic [N:0]       upper_sum;
    logic [2*N:0]     acc_step;
    logic [2*N-1:0]   product;

    assign start_ok  = i_start && ((state == S_IDLE) || (state == S_DONE));
    assign last_iter = (count == CW'(N - 1));

    // Operands are multiplied as magnitudes; -2^(N-1) still fits unsigned in N bits.
    assign a_mag = (i_signed && i_A[N-1]) ? (-i_A) : i_A;
    assign b_mag = (i_signed && i_B[N-1]) ? (-i_B) : i_B;

    always_comb begin
        upper_sum = acc[2*N:N];
        if (acc[0]) begin
            upper_sum = acc[2*N:N] + {1'b0, mcand};
        end
        acc_step = {1'b0, upper_sum, acc[N-1:1]};
        product  = neg ? (-acc[2*N-1:0]) : acc[2*N-1:0];
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_RUN;
            S_RUN:   if (last_iter) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = i_start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state == S_RUN);
        o_done = (state == S_DONE);
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            count <= '0;
            mcand <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            o_HI  <= '0;
            o_LO  <= '0;
        end else if (start_ok) begin
            count <= '0;
            mcand <= a_mag;
            acc   <= {{(N+1){1'b0}}, b_mag};
            neg   <= i_signed && (i_A[N-1] ^ i_B[N-1]);
        end else if (state == S_RUN) begin
            count <= count + 1'b1;
            acc   <= acc_step;
        end else if (state == S_FIX) begin
            o_HI <= product[2*N-1:N];
            o_LO <= product[N-1:0];
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized checks of seq_multiplier against a plain-arithmetic
// 64-bit product model, including latency, busy width, hold and reset abort.
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    seq_multiplier #(.N(32)) dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_start (start),
        .i_signed(sgn),
        .i_A     (a),
        .i_B     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_HI    (hi),
        .o_LO    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Waits for o_done after the start edge; counts busy cycles and watches HI/LO hold.
    task automatic wait_done(input bit scramble, output int edges, output int busy_cnt,
                             output bit hold_ok);
        edges   = 0;
        hold_ok = 1'b1;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                edges = k;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            if ((hi !== exp_hi) || (lo !== exp_lo)) hold_ok = 1'b0;
            if (scramble) begin
                a   = $urandom;
                b   = $urandom;
                sgn = $urandom_range(0, 1);
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic s);
        int edges;
        int busy_cnt;
        bit hold_ok;
        logic [63:0] p;
        p = model(x, y, s);
        @(negedge clk);
        a = x; b = y; sgn = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, edges, busy_cnt, hold_ok);
        check({tag, "_latency"}, 64'(edges), 64'd33);
        check({tag, "_busy"}, 64'(busy_cnt), 64'd32);
        check({tag, "_hold"}, 64'(hold_ok), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(p[63:32]));
        check({tag, "_lo"}, 64'(lo), 64'(p[31:0]));
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        int edges;
        int busy_cnt;
        bit hold_ok;
        int done_seen;
        logic [31:0] rx;
        logic [31:0] ry;
        logic rs;

        checks = 0;
        errors = 0;
        exp_hi = '0;
        exp_lo = '0;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_mixed", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
        run_op("mult_ext_s", 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op("mult_ext_u", 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Abort mid-run: no partial result, no done pulse afterwards.
        @(negedge clk);
        a = 32'd7; b = 32'd9; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        done_seen = 0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_cnt++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_idle", 64'(busy_cnt), 64'd0);
        run_op("after_abort", 32'd7, 32'd9, 1'b0);

        // Start held through RUN with scrambled operands, then back-to-back restart.
        @(negedge clk);
        a = 32'd100; b = 32'd3; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(1'b1, edges, busy_cnt, hold_ok);
        check("hs_latency", 64'(edges), 64'd33);
        check("hs_busy", 64'(busy_cnt), 64'd32);
        check("hs_hold", 64'(hold_ok), 64'd1);
        check("hs_hi", 64'(hi), 64'd0);
        check("hs_lo", 64'(lo), 64'd300);
        exp_hi = 32'd0;
        exp_lo = 32'd300;
        a = 32'd12; b = 32'd12; sgn = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(1'b0, edges, busy_cnt, hold_ok);
        check("b2b_latency", 64'(edges), 64'd33);
        check("b2b_hold", 64'(hold_ok), 64'd1);
        check("b2b_hi", 64'(hi), 64'd0);
        check("b2b_lo", 64'(lo), 64'h90);
        exp_hi = 32'd0;
        exp_lo = 32'h90;

        // Zero with negative sign, then hold for 10 idle cycles.
        run_op("zero_neg", 32'h0000_0000, 32'h8000_0000, 1'b1);
        done_seen = 1;
        hold_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
            if ((hi !== 32'd0) || (lo !== 32'd0)) hold_ok = 1'b0;
        end
        check("zero_pulses", 64'(done_seen), 64'd1);
        check("zero_hold", 64'(hold_ok), 64'd1);

        for (int i = 0; i < 16; i++) begin
            rx = $urandom;
            ry = $urandom;
            rs = $urandom_range(0, 1);
            if (i % 4 == 0) rx[31] = 1'b1;
            run_op($sformatf("rand%0d", i), rx, ry, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
